mandelbrot_display: RTL and testbench

Downstream display stage for the Mandelbrot fractal pipeline. Generates VGA raster timing and drives the shared `cx`/`cy` read address into N_COMP interleaved line engines. Selects the engine that owns the current row, and maps its iteration count to RGB. Output is blanked until every line engine reports ready; enabling is frame-aligned so no partial frame is ever shown.

---
 rtl/mandelbrot_pkg.sv | 32 +++
 rtl/mandelbrot_display_vga_timing.sv | 57 +++++
 rtl/mandelbrot_display.sv | 127 ++++++++++++
 tb/tb_mandelbrot_display.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/mandelbrot_pkg.sv
// Shared constants and types for the Mandelbrot display stage: default 640x480@60
// raster timing, the colour pixel struct and the 16-entry palette.
package mandelbrot_pkg;

  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;

  localparam int PAL_COLOR_W = 4;

  typedef struct packed {
    logic [PAL_COLOR_W-1:0] r;
    logic [PAL_COLOR_W-1:0] g;
    logic [PAL_COLOR_W-1:0] b;
  } pixel_t;

  typedef pixel_t palette_t [16];

  // Every entry is non-black so that escaped points never vanish into the set colour.
  localparam palette_t PALETTE = '{
    12'h008, 12'h00C, 12'h04F, 12'h08F,
    12'h0CF, 12'h0FC, 12'h0F8, 12'h4F4,
    12'h8F0, 12'hCF0, 12'hFC0, 12'hF80,
    12'hF40, 12'hF08, 12'hC0F, 12'h888
  };

endpackage

// File: rtl/mandelbrot_display_vga_timing.sv
// Raster counters for the Mandelbrot display: h/v counters, active flag,
// undelayed sync pulses, cx/cy read address and frame_start.
module vga_timing #(
  parameter int   H_ACTIVE = 640,
  parameter int   H_FP     = 16,
  parameter int   H_SYNC   = 96,
  parameter int   H_BP     = 48,
  parameter int   V_ACTIVE = 480,
  parameter int   V_FP     = 10,
  parameter int   V_SYNC   = 2,
  parameter int   V_BP     = 33,
  parameter logic SYNC_POL = 1'b0
) (
  input  logic                        clk,
  input  logic                        rst,
  output logic [$clog2(H_ACTIVE)-1:0] cx,
  output logic [$clog2(V_ACTIVE)-1:0] cy,
  output logic                        active,
  output logic                        hsync,
  output logic                        vsync,
  output logic                        frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);

  logic [HW-1:0] h_cnt_reg;
  logic [VW-1:0] v_cnt_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      h_cnt_reg <= '0;
      v_cnt_reg <= '0;
    end else if (h_cnt_reg == HW'(H_TOTAL - 1)) begin
      h_cnt_reg <= '0;
      v_cnt_reg <= (v_cnt_reg == VW'(V_TOTAL - 1)) ? '0 : v_cnt_reg + VW'(1);
    end else begin
      h_cnt_reg <= h_cnt_reg + HW'(1);
    end
  end

  assign active = (h_cnt_reg < HW'(H_ACTIVE)) && (v_cnt_reg < VW'(V_ACTIVE));

  // Outside the visible area the engines see address (0,0).
  assign cx = active ? h_cnt_reg[$clog2(H_ACTIVE)-1:0] : '0;
  assign cy = active ? v_cnt_reg[$clog2(V_ACTIVE)-1:0] : '0;

  assign hsync = ((h_cnt_reg >= HW'(H_ACTIVE + H_FP)) &&
                  (h_cnt_reg <  HW'(H_ACTIVE + H_FP + H_SYNC))) ? SYNC_POL : ~SYNC_POL;
  assign vsync = ((v_cnt_reg >= VW'(V_ACTIVE + V_FP)) &&
                  (v_cnt_reg <  VW'(V_ACTIVE + V_FP + V_SYNC))) ? SYNC_POL : ~SYNC_POL;

  assign frame_start = (h_cnt_reg == '0) && (v_cnt_reg == '0);

endmodule

// File: rtl/mandelbrot_display.sv
// Mandelbrot display top: raster address out, engine select, frame-aligned show
// gating and count-to-colour map. Define MANDELBROT_PALETTE_EN for a 16-colour palette.
module mandelbrot_display
  import mandelbrot_pkg::*;
#(
  parameter int   H_ACTIVE  = VGA_H_ACTIVE,
  parameter int   H_FP      = VGA_H_FP,
  parameter int   H_SYNC    = VGA_H_SYNC,
  parameter int   H_BP      = VGA_H_BP,
  parameter int   V_ACTIVE  = VGA_V_ACTIVE,
  parameter int   V_FP      = VGA_V_FP,
  parameter int   V_SYNC    = VGA_V_SYNC,
  parameter int   V_BP      = VGA_V_BP,
  parameter logic SYNC_POL  = 1'b0,
  parameter int   N_COMP    = 4,
  parameter int   DIN_WIDTH = 32,
  parameter int   COLOR_W   = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [31:0]                   iters,
  input  logic [N_COMP*DIN_WIDTH-1:0]   line_dout,
  input  logic [N_COMP-1:0]             line_rdy,
  output logic [$clog2(H_ACTIVE)-1:0]   cx,
  output logic [$clog2(V_ACTIVE)-1:0]   cy,
  output logic                          hsync,
  output logic                          vsync,
  output logic                          de,
  output logic [COLOR_W-1:0]            r,
  output logic [COLOR_W-1:0]            g,
  output logic [COLOR_W-1:0]            b,
  output logic                          frame_start
);

  localparam int SEL_W = $clog2(N_COMP);

  logic active, hsync_raw, vsync_raw;

  vga_timing #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .SYNC_POL(SYNC_POL)
  ) u_timing (
    .clk        (clk),
    .rst        (rst),
    .cx         (cx),
    .cy         (cy),
    .active     (active),
    .hsync      (hsync_raw),
    .vsync      (vsync_raw),
    .frame_start(frame_start)
  );

  logic [DIN_WIDTH-1:0] eng_data [N_COMP];

  genvar gi;
  generate
    for (gi = 0; gi < N_COMP; gi++) begin : g_unpack
      assign eng_data[gi] = line_dout[gi*DIN_WIDTH +: DIN_WIDTH];
    end
  endgenerate

  logic [SEL_W-1:0]   sel_reg;
  logic [1:0]         de_sr_reg, hs_sr_reg, vs_sr_reg;
  logic               show_reg;
  logic [COLOR_W-1:0] r_reg, g_reg, b_reg;
  logic [COLOR_W-1:0] r_next, g_next, b_next;
  logic [DIN_WIDTH-1:0] count;

  // Screen rows are interleaved across engines, so the low row bits pick the owner.
  assign count = eng_data[sel_reg];

  always_comb begin
    r_next = '0;
    g_next = '0;
    b_next = '0;
    if (de_sr_reg[0] && (count < iters)) begin
`ifdef MANDELBROT_PALETTE_EN
      r_next = COLOR_W'(PALETTE[count[3:0]].r);
      g_next = COLOR_W'(PALETTE[count[3:0]].g);
      b_next = COLOR_W'(PALETTE[count[3:0]].b);
`else
      r_next = count[COLOR_W-1:0];
      g_next = count[COLOR_W-1:0];
      b_next = count[COLOR_W-1:0];
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sel_reg   <= '0;
      de_sr_reg <= '0;
      hs_sr_reg <= {2{~SYNC_POL}};
      vs_sr_reg <= {2{~SYNC_POL}};
      r_reg     <= '0;
      g_reg     <= '0;
      b_reg     <= '0;
    end else begin
      sel_reg   <= cy[SEL_W-1:0];
      de_sr_reg <= {de_sr_reg[0], active};
      hs_sr_reg <= {hs_sr_reg[0], hsync_raw};
      vs_sr_reg <= {vs_sr_reg[0], vsync_raw};
      r_reg     <= r_next;
      g_reg     <= g_next;
      b_reg     <= b_next;
    end
  end

  // Loss of readiness blanks at once; recovery only takes effect on a frame boundary.
  always_ff @(posedge clk) begin
    if (rst)
      show_reg <= 1'b0;
    else if (!(&line_rdy))
      show_reg <= 1'b0;
    else if (frame_start)
      show_reg <= 1'b1;
  end

  assign de    = de_sr_reg[1];
  assign hsync = hs_sr_reg[1];
  assign vsync = vs_sr_reg[1];
  assign r     = show_reg ? r_reg : '0;
  assign g     = show_reg ? g_reg : '0;
  assign b     = show_reg ? b_reg : '0;

endmodule

// File: tb/tb_mandelbrot_display.sv
// Randomised bench for mandelbrot_display on a shrunken raster, checked every cycle
// against a position-from-cycle-count model plus a few hand-computed pixels.
module tb_mandelbrot_display;
  import mandelbrot_pkg::*;

  localparam int HA = 16, HF = 2, HS = 3, HB = 3;
  localparam int VA = 12, VF = 1, VS = 2, VB = 1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FT = HT * VT;
  localparam int NC = 4, DW = 32, CW = 4;
  localparam int XW = $clog2(HA), YW = $clog2(VA);

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [31:0]      iters = 32'd100;
  logic [NC*DW-1:0] line_dout = '0;
  logic [NC-1:0]    line_rdy = '0;
  logic [XW-1:0]    cx;
  logic [YW-1:0]    cy;
  logic hsync, vsync, de, frame_start;
  logic [CW-1:0] r, g, b;

  int compared = 0;
  int mismatched = 0;

  int mem [NC][VA/NC][HA];

  int          n = 0;
  logic        started = 1'b0;
  logic        show_m = 1'b0;
  logic [31:0] iters_prev = '0;

  always #5 clk = ~clk;

  mandelbrot_display #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .SYNC_POL(1'b0), .N_COMP(NC), .DIN_WIDTH(DW), .COLOR_W(CW)
  ) dut (
    .clk(clk), .rst(rst), .iters(iters), .line_dout(line_dout), .line_rdy(line_rdy),
    .cx(cx), .cy(cy), .hsync(hsync), .vsync(vsync), .de(de),
    .r(r), .g(g), .b(b), .frame_start(frame_start)
  );

  // Line engines: registered read of the row each one owns.
  always @(posedge clk) begin
    for (int k = 0; k < NC; k++)
      line_dout[k*DW +: DW] <= DW'(mem[k][int'(cy) / NC][int'(cx)]);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, n, act, exp);
    end
  endtask

  function automatic logic [3*CW-1:0] colour(input int cnt, input logic [31:0] it);
    if (cnt >= int'(it)) return '0;
`ifdef MANDELBROT_PALETTE_EN
    return {CW'(PALETTE[cnt % 16].r), CW'(PALETTE[cnt % 16].g), CW'(PALETTE[cnt % 16].b)};
`else
    return {3{CW'(cnt % (1 << CW))}};
`endif
  endfunction

  // Model state: cycles since reset, expected show flag, last-cycle iters.
  always @(posedge clk) begin
    if (rst) begin
      n       <= 0;
      show_m  <= 1'b0;
      started <= 1'b1;
    end else begin
      n <= n + 1;
      if (!(&line_rdy)) show_m <= 1'b0;
      else if ((n % FT) == 0) show_m <= 1'b1;
    end
    iters_prev <= iters;
  end

  int h0, v0, hp, vp;
  logic a0, de_e, hs_e, vs_e;
  logic [3*CW-1:0] rgb_e;

  always @(negedge clk) begin
    if (started) begin
      h0 = n % HT;
      v0 = (n / HT) % VT;
      a0 = (h0 < HA) && (v0 < VA);
      chk("cx", 32'(cx), a0 ? h0 : 0);
      chk("cy", 32'(cy), a0 ? v0 : 0);
      chk("frame_start", 32'(frame_start), 32'((n % FT) == 0));
      de_e = 1'b0; hs_e = 1'b1; vs_e = 1'b1; rgb_e = '0;
      if (n >= 2) begin
        hp   = (n - 2) % HT;
        vp   = ((n - 2) / HT) % VT;
        de_e = (hp < HA) && (vp < VA);
        hs_e = !((hp >= HA + HF) && (hp < HA + HF + HS));
        vs_e = !((vp >= VA + VF) && (vp < VA + VF + VS));
        if (de_e && show_m)
          rgb_e = colour(mem[vp % NC][vp / NC][hp], iters_prev);
      end
      chk("hsync", 32'(hsync), 32'(hs_e));
      chk("vsync", 32'(vsync), 32'(vs_e));
      chk("de", 32'(de), 32'(de_e));
      chk("r", 32'(r), 32'(rgb_e[3*CW-1 -: CW]));
      chk("g", 32'(g), 32'(rgb_e[2*CW-1 -: CW]));
      chk("b", 32'(b), 32'(rgb_e[CW-1 -: CW]));
    end
  end

  initial begin
    int hs_low, hs_first, vs_low, de_cnt, nz_cnt;
    for (int k = 0; k < NC; k++)
      for (int rr = 0; rr < VA / NC; rr++)
        for (int cc = 0; cc < HA; cc++)
          mem[k][rr][cc] = int'($urandom_range(0, 20));
    mem[1][1][3] = 7;    // screen row 5, column 3
    mem[2][0][4] = 100;  // screen row 2, column 4
    mem[3][0][4] = 9;    // screen row 3, column 4

    rst = 1'b1; iters = 32'd100; line_rdy = 4'b0111;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    hs_low = 0; hs_first = -1; vs_low = 0; de_cnt = 0; nz_cnt = 0;

    for (int c = 0; c < 5*FT + 4*HT + 7; c++) begin
      if (c == 0) begin
        chk("release_hsync", 32'(hsync), 32'd1);
        chk("release_vsync", 32'(vsync), 32'd1);
        chk("release_de", 32'(de), 32'd0);
        chk("first_frame_start", 32'(frame_start), 32'd1);
      end
      if (c < HT && hsync == 1'b0) begin
        hs_low++;
        if (hs_first < 0) hs_first = c;
      end
      if (c < FT) begin
        if (!vsync) vs_low++;
        if (de) de_cnt++;
        if ((r | g | b) != '0) nz_cnt++;
      end
      if (c == HT) begin
        chk("hsync_width", hs_low, HS);
        chk("hsync_start", hs_first, HA + HF + 2);
      end
      if (c == FT) begin
        chk("vsync_width", vs_low, VS * HT);
        chk("de_count", de_cnt, HA * VA);
        chk("not_ready_black", nz_cnt, 0);
        chk("second_frame_start", 32'(frame_start), 32'd1);
      end
      if (c == 200) line_rdy = 4'b1111;
      if (c == FT + 5*HT + 3 + 2) begin
        chk("pin_de", 32'(de), 32'd1);
`ifdef MANDELBROT_PALETTE_EN
        chk("pin_r", 32'(r), 32'(PALETTE[7].r));
`else
        chk("pin_r", 32'(r), 32'd7);
        chk("pin_g", 32'(g), 32'd7);
        chk("pin_b", 32'(b), 32'd7);
`endif
      end
      if (c == FT + 2*HT + 4 + 2) begin
        chk("inset_de", 32'(de), 32'd1);
        chk("inset_black", 32'(r | g | b), 32'd0);
      end
      if (c == FT + VA*HT) iters = 32'd101;
      if (c == 2*FT + 2*HT + 4 + 2)
        chk("below_iters_nonzero", 32'((r | g | b) != '0), 32'd1);
      if (c >= 3*FT && c < 4*FT) iters = $urandom_range(3, 24);
      if (c == 4*FT) iters = 32'd100;
      if (c == 4*FT + 3*HT + 5) line_rdy = 4'b1011;
      if (c == 4*FT + 3*HT + 6) chk("drop_blank", 32'(r | g | b), 32'd0);
      if (c == 4*FT + 3*HT + 20) line_rdy = 4'b1111;
      if (c >= 5*FT) begin
        iters = $urandom_range(3, 24);
        line_rdy = ($urandom_range(0, 31) == 0) ? 4'($urandom_range(0, 15)) : 4'hF;
      end
      @(negedge clk);
    end

    rst = 1'b1; line_rdy = 4'hF;
    @(negedge clk);
    chk("reset_cx", 32'(cx), 32'd0);
    chk("reset_cy", 32'(cy), 32'd0);
    chk("reset_frame_start", 32'(frame_start), 32'd1);
    chk("reset_de", 32'(de), 32'd0);
    rst = 1'b0;
    $display("mid-line reset applied, running randomised frames");

    for (int c = 0; c < 2*FT; c++) begin
      if (c == FT) chk("post_reset_frame_start", 32'(frame_start), 32'd1);
      iters = $urandom_range(3, 24);
      line_rdy = ($urandom_range(0, 63) == 0) ? 4'($urandom_range(0, 15)) : 4'hF;
      @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
